sam_enc_ctrl: RTL and testbench
===============================

# sam_enc_ctrl

Command sequencer for the SAM encoder. It takes one parallel command (key length exponent, d key, N key, message word) and serialises it onto the encoder's `str`/`mode` inputs. The configuration phase is sent as raw bits and the message as pulse-width symbols. The block then captures the encoder's `msgcd` on its `valid` pulse and returns it through a valid/ready response port.

## Interface
- `SYM_LEN`, 16: cycles per message symbol; legal 10..60.
- `HI_LONG`, 10: high cycles of a '1' symbol; a '0' uses `SYM_LEN-HI_LONG` high cycles; requires `SYM_LEN/2 < HI_LONG < SYM_LEN`.
- `TIMEOUT`, 256: watchdog limit in cycles (only with macro).

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: asynchronous, active-low.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_n` in 4: exponent; key/message length `L = 1<<cmd_n`.
- `cmd_d` in 16: d key; bits `[L-1:0]` used.
- `cmd_cn` in 16: N key; bits `[L-1:0]` used.
- `cmd_msg` in 16: message; bits `[L-1:0]` used.
- `enc_str` out 1: encoder serial data.
- `enc_mode` out 1: encoder mode.
- `enc_msgcd` in 16: encoder result.
- `enc_valid` in 1: encoder one-cycle done pulse.
- `rsp_valid` out 1: response held until taken.
- `rsp_ready` in 1: response accepted.
- `rsp_code` out 16: `enc_msgcd` masked to `L` bits; upper bits 0.
- `rsp_err` out 1: command rejected or timed out.
- `busy` out 1: high when not IDLE.

## Operation
- Reset values:
  - `enc_str=0`, `enc_mode=0`, `rsp_valid=0`, `rsp_code=0`, `rsp_err=0`, `busy=0`.
  - `cmd_ready=1`; state IDLE.
- All outputs are registered.
- States: IDLE, CFG_N, CFG_D, CFG_CN, SETUP, SYM, TAIL, WAIT_VLD, RESP.
- IDLE:
  - On the `cmd_valid && cmd_ready` edge, latch all command fields.
  - If `cmd_n > 4`, go to RESP with `rsp_err=1`, `rsp_code=0`; encoder pins stay 0.
  - Otherwise drive `enc_mode=1`, `enc_str=cmd_n[3]` and go to CFG_N.
- CFG_N: send `n[2]`, `n[1]`, `n[0]` on the following 3 edges, then CFG_D.
- CFG_D: send `d[L-1]` down to `d[0]`, one bit per cycle.
- CFG_CN: send `N[L-1]` down to `N[0]`. `enc_mode` stays 1 from acceptance through the last N bit; it must never drop early, or the encoder aborts to start.
- SETUP: one cycle with `enc_mode=0`, `enc_str=0`. The encoder spends this cycle in its norm-entry register copy.
- SYM: `L` symbols, message bit `L-1` first. Each symbol is `H` cycles with `enc_str=1`, then `SYM_LEN-H` cycles with `enc_str=0`.
  - Bit=1: `H=HI_LONG`.
  - Bit=0: `H=SYM_LEN-HI_LONG`.
- TAIL: one cycle with `enc_str=1`. This rising edge terminates the last symbol. `enc_str` then returns to 0.
- WAIT_VLD: on `enc_valid=1`, capture `rsp_code = enc_msgcd & ((1<<L)-1)`, set `rsp_err=0`, go to RESP.
- RESP: hold `rsp_valid=1` and data stable until `rsp_ready=1`. On that edge clear `rsp_valid` and return to IDLE; a new command can be accepted on the next edge.
- Counters:
  - Bit index: 5 bits, counts `L-1` down to 0.
  - Symbol phase counter: 6 bits.
  - Timeout counter: `$clog2(TIMEOUT+1)` bits.
- `enc_valid` outside WAIT_VLD is ignored.
- `cmd_valid` while busy is ignored (`cmd_ready=0`).
- Reset asserted mid-command: all outputs return to reset values immediately; the in-flight command is discarded with no response.

## Timing
- Acceptance edge = edge 0. `enc_mode`/`enc_str` change on edge 0; the encoder samples the first n bit at edge 1.
- Config bits occupy edges 0 .. `3+2L`. SETUP is edge `4+2L`.
- First symbol starts at edge `5+2L`. TAIL is at edge `5+2L+L*SYM_LEN`.
- `enc_valid` is expected 2 cycles after TAIL. `rsp_valid` rises on the edge after `enc_valid` is sampled.
- Rejected command (`n>4`): `rsp_valid` rises at edge 1.
- Minimum spacing between accepted commands: full sequence + RESP handshake + 1 cycle.

## Configuration
- `SAM_CTRL_TIMEOUT_EN` defined:
  - WAIT_VLD counts cycles.
  - If `enc_valid` is not seen within `TIMEOUT` cycles of entering WAIT_VLD, go to RESP with `rsp_err=1`, `rsp_code=0`.
- Undefined: no counter; WAIT_VLD waits indefinitely; `rsp_err` is set only by `n>4`.

## Test plan
- n=2, d=0xA, N=0x1, msg=0x6 -> 4+4+4 config bits, 4 symbols (0,1,1,0), `rsp_code=0x000D`, `rsp_err=0`.
- n=4, d=0xFFFF, N=0x0000, msg=0x1234 -> `rsp_code=0xEDCB`; `enc_mode` high exactly 36 cycles.
- n=0, d=0, N=0, msg=1 -> one '1' symbol of 10 high / 6 low, then TAIL; `rsp_code=0x0001`.
- n=5 -> no encoder activity; `rsp_valid` at edge 1 with `rsp_err=1`, `rsp_code=0`.
- `rsp_ready` held low 20 cycles after `rsp_valid` -> response stable and `cmd_ready=0` throughout; IDLE is entered on the edge `rsp_ready` rises. Reset pulsed mid-CFG_D -> all outputs return to reset values at once.
- With `SAM_CTRL_TIMEOUT_EN`, `TIMEOUT=64`, `enc_valid` tied 0 -> `rsp_err=1` exactly 64 cycles after entering WAIT_VLD.

Source files
------------

// File: rtl/sam_enc_ctrl.sv
// rtl/sam_enc_ctrl.sv - command sequencer serialising one SAM encoder command
//
// Purpose:
//   Accepts one parallel command (n, d, N, msg) and serialises it onto the SAM encoder.
//   The configuration (n, d, N) goes out as raw bits with enc_mode=1.
//   The message goes out as pulse-width symbols with enc_mode=0.
//   The encoder result is then captured and returned on a valid/ready response port.
//
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   cmd_valid/ready : command handshake; cmd_ready is high only while idle
//   cmd_n           : length exponent, L = 1<<cmd_n (values above 4 are rejected)
//   cmd_d/cn/msg    : d key, N key and message, bits [L-1:0] used
//   enc_str/mode    : serial data and mode pins to the encoder
//   enc_msgcd/valid : encoder result and its one-cycle done pulse
//   rsp_valid/ready : response handshake; response is held until taken
//   rsp_code/err    : masked result, error flag (reject or watchdog)
//   busy            : high whenever a command is in flight
//
// Optional feature: define SAM_CTRL_TIMEOUT_EN to enable a WAIT_VLD watchdog
// of TIMEOUT cycles. When it is undefined, WAIT_VLD waits indefinitely.
module sam_enc_ctrl #(
  parameter int SYM_LEN = 16,
  parameter int HI_LONG = 10
`ifdef SAM_CTRL_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 256
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_n,
  input  logic [15:0] cmd_d,
  input  logic [15:0] cmd_cn,
  input  logic [15:0] cmd_msg,
  output logic        enc_str,
  output logic        enc_mode,
  input  logic [15:0] enc_msgcd,
  input  logic        enc_valid,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_code,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, CFG_N, CFG_D, CFG_CN, SETUP, SYM, TAIL, WAIT_VLD, RESP
  } state_t;

  state_t      state;
  logic [2:0]  n_q;      // n[3] is only ever sent on the acceptance edge
  logic [15:0] d_q;
  logic [15:0] cn_q;
  logic [15:0] msg_q;
  logic [4:0]  bit_idx;
  logic [5:0]  phase;

`ifdef SAM_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
`endif

  // Derived from the latched exponent; only meaningful for accepted commands (n<=4).
  logic [4:0]  len;
  logic [4:0]  last_idx;
  logic [15:0] len_mask;
  logic [5:0]  hi_len;

  always_comb begin
    len      = 5'd1 << n_q;
    last_idx = len - 5'd1;
    len_mask = '0;
    for (int i = 0; i < 16; i++) begin
      len_mask[i] = (5'(i) < len);
    end
    // A '1' symbol uses the long high time, and a '0' symbol uses the short one.
    hi_len = msg_q[bit_idx[3:0]] ? 6'(HI_LONG) : 6'(SYM_LEN - HI_LONG);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      n_q       <= '0;
      d_q       <= '0;
      cn_q      <= '0;
      msg_q     <= '0;
      bit_idx   <= '0;
      phase     <= '0;
      enc_str   <= 1'b0;
      enc_mode  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_code  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
`ifdef SAM_CTRL_TIMEOUT_EN
      tcnt      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            n_q       <= cmd_n[2:0];
            d_q       <= cmd_d;
            cn_q      <= cmd_cn;
            msg_q     <= cmd_msg;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            if (cmd_n > 4'd4) begin
              rsp_err  <= 1'b1;
              rsp_code <= '0;
              state    <= RESP;
            end else begin
              enc_mode <= 1'b1;
              enc_str  <= cmd_n[3];
              bit_idx  <= 5'd2;
              state    <= CFG_N;
            end
          end
        end

        CFG_N: begin
          enc_str <= n_q[bit_idx[1:0]];
          if (bit_idx == 5'd0) begin
            bit_idx <= last_idx;
            state   <= CFG_D;
          end else begin
            bit_idx <= bit_idx - 5'd1;
          end
        end

        CFG_D: begin
          enc_str <= d_q[bit_idx[3:0]];
          if (bit_idx == 5'd0) begin
            bit_idx <= last_idx;
            state   <= CFG_CN;
          end else begin
            bit_idx <= bit_idx - 5'd1;
          end
        end

        // enc_mode stays high through the last N bit. Dropping it early aborts the encoder.
        CFG_CN: begin
          enc_str <= cn_q[bit_idx[3:0]];
          if (bit_idx == 5'd0) begin
            state <= SETUP;
          end else begin
            bit_idx <= bit_idx - 5'd1;
          end
        end

        SETUP: begin
          enc_mode <= 1'b0;
          enc_str  <= 1'b0;
          bit_idx  <= last_idx;
          phase    <= '0;
          state    <= SYM;
        end

        SYM: begin
          enc_str <= (phase < hi_len);
          if (phase == 6'(SYM_LEN - 1)) begin
            phase <= '0;
            if (bit_idx == 5'd0) begin
              state <= TAIL;
            end else begin
              bit_idx <= bit_idx - 5'd1;
            end
          end else begin
            phase <= phase + 6'd1;
          end
        end

        // The rising edge here terminates the final symbol.
        TAIL: begin
          enc_str <= 1'b1;
          state   <= WAIT_VLD;
`ifdef SAM_CTRL_TIMEOUT_EN
          tcnt    <= '0;
`endif
        end

        WAIT_VLD: begin
          enc_str <= 1'b0;
          if (enc_valid) begin
            rsp_code <= enc_msgcd & len_mask;
            rsp_err  <= 1'b0;
            state    <= RESP;
          end
`ifdef SAM_CTRL_TIMEOUT_EN
          else if (tcnt == TW'(TIMEOUT - 1)) begin
            rsp_code <= '0;
            rsp_err  <= 1'b1;
            state    <= RESP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end

        // rsp_valid is raised one edge after entry, so code and err are settled before valid.
        RESP: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sam_enc_ctrl.sv
// tb/tb_sam_enc_ctrl.sv - self-checking bench for sam_enc_ctrl with an encoder stub
module tb_sam_enc_ctrl;
  localparam int SYM_LEN = 16;
  localparam int HI_LONG = 10;
`ifdef SAM_CTRL_TIMEOUT_EN
  localparam int TO_CYC = 64;
`else
  localparam int TO_CYC = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_n = '0;
  logic [15:0] cmd_d = '0;
  logic [15:0] cmd_cn = '0;
  logic [15:0] cmd_msg = '0;
  logic        enc_str;
  logic        enc_mode;
  logic [15:0] enc_msgcd = '0;
  logic        enc_valid = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_code;
  logic        rsp_err;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected encoder pins after each edge, counted from the acceptance edge.
  bit exp_m[$];
  bit exp_s[$];

  sam_enc_ctrl #(
    .SYM_LEN(SYM_LEN),
    .HI_LONG(HI_LONG)
`ifdef SAM_CTRL_TIMEOUT_EN
    ,
    .TIMEOUT(TO_CYC)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_n(cmd_n), .cmd_d(cmd_d), .cmd_cn(cmd_cn), .cmd_msg(cmd_msg),
    .enc_str(enc_str), .enc_mode(enc_mode),
    .enc_msgcd(enc_msgcd), .enc_valid(enc_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_code(rsp_code), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit m, input bit s);
    exp_m.push_back(m);
    exp_s.push_back(s);
  endtask

  // Build the expected pin stream: config bits with mode high, the setup cycle,
  // pulse-width symbols, and the tail pulse.
  task automatic build_expect(input int n, input logic [15:0] d, input logic [15:0] cn,
                              input logic [15:0] msg);
    int len;
    int h;
    exp_m.delete();
    exp_s.delete();
    if (n > 4) return;
    len = 1 << n;
    for (int i = 3; i >= 0; i--) push(1'b1, bit'((n >> i) & 1));
    for (int i = len - 1; i >= 0; i--) push(1'b1, d[i]);
    for (int i = len - 1; i >= 0; i--) push(1'b1, cn[i]);
    push(1'b0, 1'b0);
    for (int i = len - 1; i >= 0; i--) begin
      h = msg[i] ? HI_LONG : SYM_LEN - HI_LONG;
      for (int c = 0; c < SYM_LEN; c++) push(1'b0, c < h);
    end
    push(1'b0, 1'b1);
  endtask

  task automatic run_cmd(input int n, input logic [15:0] d, input logic [15:0] cn,
                         input logic [15:0] msg, input logic [15:0] code, input int hold,
                         input bit give_vld, input int abort_at);
    int tail;
    int rsp_edge;
    int werr = 0;
    int berr = 0;
    int lerr = 0;
    int serr = 0;
    int wcnt = 0;
    bit em;
    bit es;
    bit exp_err;
    logic [15:0] exp_code;
    logic [15:0] mask;
    build_expect(n, d, cn, msg);
    mask = (n <= 4) ? 16'((32'd1 << (1 << n)) - 1) : 16'h0;
    if (n > 4) begin
      tail = -10; rsp_edge = 1; exp_err = 1'b1; exp_code = 16'h0;
    end else begin
      tail = exp_m.size() - 1;
      if (give_vld) begin
        rsp_edge = tail + 3; exp_err = 1'b0; exp_code = code & mask;
      end else begin
        rsp_edge = tail + TO_CYC + 1; exp_err = 1'b1; exp_code = 16'h0;
      end
    end
    while (cmd_ready !== 1'b1 && wcnt < 20) begin
      @(negedge clk);
      wcnt++;
    end
    check_eq("cmd_ready_before", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_n = 4'(n); cmd_d = d; cmd_cn = cn; cmd_msg = msg;
    for (int k = 0; k <= rsp_edge; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 0) begin
        // Scramble the inputs to prove the command was latched.
        cmd_valid = 1'b0;
        cmd_n = 4'($urandom); cmd_d = 16'($urandom); cmd_cn = 16'($urandom); cmd_msg = 16'($urandom);
      end
      if (k == abort_at) begin
        reset = 1'b0;
        #1;
        check_eq("abort_mode", {31'd0, enc_mode}, 32'd0);
        check_eq("abort_str", {31'd0, enc_str}, 32'd0);
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("abort_rsp", {15'd0, rsp_valid, rsp_err, rsp_code}, 32'd0);
        enc_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int j = 0; j < 50; j++) begin
          @(negedge clk);
          if (enc_mode !== 1'b0 || enc_str !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) serr++;
        end
        check_eq("abort_quiet", serr, 0);
        return;
      end
      em = (k < exp_m.size()) ? exp_m[k] : 1'b0;
      es = (k < exp_s.size()) ? exp_s[k] : 1'b0;
      if (enc_mode !== em || enc_str !== es) werr++;
      if (busy !== 1'b1 || cmd_ready !== 1'b0) berr++;
      if (rsp_valid !== (k == rsp_edge)) lerr++;
      enc_valid = 1'b0;
      enc_msgcd = 16'($urandom);
      if (n <= 4 && give_vld && k + 1 == tail + 2) begin
        enc_valid = 1'b1;
        enc_msgcd = code;
      end else if (k + 1 <= tail) begin
        enc_valid = ($urandom_range(0, 7) == 0);
      end
    end
    enc_valid = 1'b0;
    check_eq("wave_mismatch_cycles", werr, 0);
    check_eq("busy_ready_errs", berr, 0);
    check_eq("rsp_valid_timing_errs", lerr, 0);
    check_eq("rsp_code", {16'd0, rsp_code}, {16'd0, exp_code});
    check_eq("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_code !== exp_code || rsp_err !== exp_err ||
          cmd_ready !== 1'b0 || busy !== 1'b1) serr++;
    end
    check_eq("rsp_hold_errs", serr, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("post_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check_eq("post_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_eq("rst_str", {31'd0, enc_str}, 32'd0);
    check_eq("rst_mode", {31'd0, enc_mode}, 32'd0);
    check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_rsp_code", {16'd0, rsp_code}, 32'd0);
    check_eq("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    reset = 1'b1;
    @(negedge clk);

    run_cmd(2, 16'h000A, 16'h0001, 16'h0006, 16'hABCD, 3, 1'b1, -1);
    run_cmd(4, 16'hFFFF, 16'h0000, 16'h1234, 16'hEDCB, 20, 1'b1, -1);
    run_cmd(0, 16'h0000, 16'h0000, 16'h0001, 16'hFFFF, 0, 1'b1, -1);
    run_cmd(5, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 2, 1'b1, -1);
    run_cmd(4, 16'h5A5A, 16'hC3C3, 16'h0F0F, 16'h1234, 0, 1'b1, 8);
`ifdef SAM_CTRL_TIMEOUT_EN
    run_cmd(0, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 1, 1'b0, -1);
`endif
    for (int i = 0; i < 20; i++) begin
      n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 15)) : int'($urandom_range(0, 4));
      run_cmd(n, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
              int'($urandom_range(0, 4)), 1'b1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
